sfr_target_regfile: RTL and testbench

Register-file target for the SFR bus: the downstream stage that consumes the address/write_data/we/re transactions issued by the SFR master and returns read_data. Holds a bank of general-purpose read/write registers plus a small control/status block (ID, write lock, write and error counters, maskable interrupt). Used as the DUT-side endpoint in SFR agent benches and as the register front end of small peripherals.

---
 rtl/sfr_target_regfile.sv | 131 +++++++++++++
 tb/tb_sfr_target_regfile.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sfr_target_regfile.sv
// SFR bus register-file target: general-purpose RW registers plus an ID, write-lock,
// error/write counters and a maskable two-source interrupt. Reads are combinational.
module sfr_target_regfile #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_GP     = 16,
    parameter logic [7:0]  ID_VALUE   = 8'h5A,
    parameter logic [7:0]  LOCK_KEY   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  irq,
    output logic                  locked
);

    localparam int unsigned GP_IDX_W = (NUM_GP > 1) ? $clog2(NUM_GP) : 1;
    localparam int unsigned IRQ_W    = 2;

    localparam logic [ADDR_WIDTH-1:0] A_ID   = ADDR_WIDTH'(8'hF0);
    localparam logic [ADDR_WIDTH-1:0] A_LOCK = ADDR_WIDTH'(8'hF1);
    localparam logic [ADDR_WIDTH-1:0] A_ERR  = ADDR_WIDTH'(8'hF2);
    localparam logic [ADDR_WIDTH-1:0] A_WR   = ADDR_WIDTH'(8'hF3);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(8'hF4);
    localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(8'hF5);

    logic [DATA_WIDTH-1:0] gp [NUM_GP];
    logic [DATA_WIDTH-1:0] lock_reg;
    logic [DATA_WIDTH-1:0] err_cnt;
    logic [DATA_WIDTH-1:0] wr_cnt;
    logic [IRQ_W-1:0]      irq_stat;
    logic [IRQ_W-1:0]      irq_mask;

    logic                  is_gp, is_id, is_lock, is_err, is_wr, is_stat, is_mask, mapped;
    logic                  wr_ok, err_evt, err_clr, wrap, gp_wr;
    logic [GP_IDX_W-1:0]   gp_idx;
    logic [DATA_WIDTH-1:0] lock_nxt, err_nxt, wr_nxt;
    logic [IRQ_W-1:0]      stat_nxt, mask_nxt;

    // Address decode and transfer classification
    always_comb begin
        is_gp   = address < ADDR_WIDTH'(NUM_GP);
        is_id   = address == A_ID;
        is_lock = address == A_LOCK;
        is_err  = address == A_ERR;
        is_wr   = address == A_WR;
        is_stat = address == A_STAT;
        is_mask = address == A_MASK;
        mapped  = is_gp | is_id | is_lock | is_err | is_wr | is_stat | is_mask;
        gp_idx  = address[GP_IDX_W-1:0];

        // A simultaneous write owns the cycle; read side effects only apply to pure reads
        wr_ok   = we & ((is_gp & ~locked) | is_lock | is_stat | is_mask);
        err_evt = (we & ~wr_ok) | (re & ~we & ~mapped);
        err_clr = re & ~we & is_err;
        wrap    = wr_ok & (wr_cnt == '1);
        gp_wr   = wr_ok & is_gp;
    end

    // Next values for the control/status block
    always_comb begin
        lock_nxt = (wr_ok & is_lock) ? write_data : lock_reg;
        mask_nxt = (wr_ok & is_mask) ? write_data[IRQ_W-1:0] : irq_mask;
        wr_nxt   = wr_ok ? (wr_cnt + DATA_WIDTH'(1)) : wr_cnt;

        err_nxt = err_clr ? '0 : err_cnt;
        if (err_evt && (err_nxt != '1)) begin
            err_nxt = err_nxt + DATA_WIDTH'(1);
        end

        // Hardware set is applied after W1C so it wins in a collision
        stat_nxt = irq_stat;
        if (wr_ok && is_stat) begin
            stat_nxt = irq_stat & ~write_data[IRQ_W-1:0];
        end
        stat_nxt = stat_nxt | {wrap, err_evt};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp[i] <= '0;
            end
            lock_reg <= '0;
            err_cnt  <= '0;
            wr_cnt   <= '0;
            irq_stat <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
            locked   <= 1'b1;
        end else begin
            if (gp_wr) begin
                gp[gp_idx] <= write_data;
            end
            lock_reg <= lock_nxt;
            err_cnt  <= err_nxt;
            wr_cnt   <= wr_nxt;
            irq_stat <= stat_nxt;
            irq_mask <= mask_nxt;
            irq      <= |(stat_nxt & mask_nxt);
            locked   <= lock_nxt[7:0] != LOCK_KEY;
        end
    end

    // Read mux: zero when no read strobe or unmapped
    always_comb begin
        read_data = '0;
        if (re) begin
            if (is_gp) begin
                read_data = gp[gp_idx];
            end else if (is_id) begin
                read_data = DATA_WIDTH'(ID_VALUE);
            end else if (is_lock) begin
                read_data = lock_reg;
            end else if (is_err) begin
                read_data = err_cnt;
            end else if (is_wr) begin
                read_data = wr_cnt;
            end else if (is_stat) begin
                read_data = {{(DATA_WIDTH-IRQ_W){1'b0}}, irq_stat};
            end else if (is_mask) begin
                read_data = {{(DATA_WIDTH-IRQ_W){1'b0}}, irq_mask};
            end
        end
    end

endmodule

// File: tb/tb_sfr_target_regfile.sv
// Directed plus randomized bench for sfr_target_regfile, checked against a
// transaction-level model of the register map.
module tb_sfr_target_regfile;

    logic       clk;
    logic       reset;
    logic [7:0] address;
    logic [7:0] write_data;
    logic       we;
    logic       re;
    logic [7:0] read_data;
    logic       irq;
    logic       locked;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_gp [16];
    int m_lock, m_err, m_wr, m_stat, m_mask;

    sfr_target_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .we         (we),
        .re         (re),
        .read_data  (read_data),
        .irq        (irq),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_gp[i] = 0;
        m_lock = 0; m_err = 0; m_wr = 0; m_stat = 0; m_mask = 0;
    endfunction

    function automatic int exp_rd(int a, bit r);
        if (!r) return 0;
        if (a < 16) return m_gp[a];
        case (a)
            'hF0: return 'h5A;
            'hF1: return m_lock;
            'hF2: return m_err;
            'hF3: return m_wr;
            'hF4: return m_stat;
            'hF5: return m_mask;
            default: return 0;
        endcase
    endfunction

    function automatic void note_error();
        if (m_err < 255) m_err++;
        m_stat = m_stat | 1;
    endfunction

    function automatic void model_step(bit w, bit r, int a, int d);
        bit acc;
        if (w) begin
            acc = (a < 16 && m_lock == 'hA5) || a == 'hF1 || a == 'hF4 || a == 'hF5;
            if (acc) begin
                if (a < 16)        m_gp[a] = d;
                else if (a == 'hF1) m_lock = d;
                else if (a == 'hF4) m_stat = m_stat & ~d & 3;
                else               m_mask = d & 3;
                m_wr = (m_wr + 1) % 256;
                if (m_wr == 0) m_stat = m_stat | 2;
            end else begin
                note_error();
            end
        end else if (r) begin
            if (!(a < 16 || (a >= 'hF0 && a <= 'hF5))) note_error();
            else if (a == 'hF2) m_err = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check read data mid-cycle, check irq/locked after the edge
    task automatic xfer(input bit w, input bit r, input int a, input int d, output logic [7:0] rd);
        @(negedge clk);
        we = w; re = r; address = 8'(a); write_data = 8'(d);
        #1;
        rd = read_data;
        chk("read_data", read_data, 8'(exp_rd(a, r)));
        @(posedge clk);
        model_step(w, r, a, d);
        #1;
        we = 1'b0; re = 1'b0;
        chk("irq", 8'(irq), 8'((m_stat & m_mask) != 0));
        chk("locked", 8'(locked), 8'(m_lock != 'hA5));
    endtask

    task automatic do_reset(input bit w, input int a, input int d);
        @(negedge clk);
        reset = 1'b0; we = w; re = 1'b0; address = 8'(a); write_data = 8'(d);
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("rst_read_data", read_data, 8'h00);
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_locked", 8'(locked), 8'h01);
        @(negedge clk);
        reset = 1'b1; we = 1'b0; re = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        reset = 1'b1; we = 1'b0; re = 1'b0; address = '0; write_data = '0;
        model_reset();

        // Reset state and ID
        do_reset(1'b0, 0, 0);
        xfer(0, 1, 'hF0, 0, rd); chk("id", rd, 8'h5A);
        xfer(0, 1, 'h00, 0, rd); chk("gp0_reset", rd, 8'h00);

        // Lock behaviour
        do_reset(1'b0, 0, 0);
        xfer(1, 0, 'h03, 'h11, rd);
        xfer(0, 1, 'h03, 0, rd);    chk("gp3_locked", rd, 8'h00);
        xfer(0, 1, 'hF2, 0, rd);    chk("err_one", rd, 8'h01);
        xfer(0, 1, 'hF2, 0, rd);    chk("err_cleared", rd, 8'h00);
        xfer(1, 0, 'hF1, 'hA5, rd);
        xfer(1, 0, 'h03, 'h11, rd);
        xfer(0, 1, 'h03, 0, rd);    chk("gp3_unlocked", rd, 8'h11);
        chk("unlocked", 8'(locked), 8'h00);
        xfer(0, 1, 'hF3, 0, rd);    chk("wr_cnt_two", rd, 8'h02);

        // Interrupt set and W1C clear
        xfer(1, 0, 'hF5, 'h01, rd);
        xfer(1, 0, 'hF0, 'h33, rd);
        chk("irq_set", 8'(irq), 8'h01);
        xfer(1, 0, 'hF4, 'h01, rd);
        chk("irq_cleared", 8'(irq), 8'h00);

        // Error counter saturation
        do_reset(1'b0, 0, 0);
        for (int i = 0; i < 256; i++) xfer(1, 0, 'hF0, i, rd);
        xfer(0, 1, 'hF2, 0, rd);    chk("err_sat", rd, 8'hFF);

        // Write counter wrap
        do_reset(1'b0, 0, 0);
        for (int i = 0; i < 256; i++) xfer(1, 0, 'hF5, 0, rd);
        xfer(0, 1, 'hF3, 0, rd);    chk("wr_wrap", rd, 8'h00);
        xfer(0, 1, 'hF4, 0, rd);    chk("wrap_stat", rd, 8'h02);

        // Read/write collision and unmapped read
        do_reset(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) xfer(1, 0, 'hF3, 0, rd);
        xfer(1, 0, 'hF1, 'hA5, rd);
        xfer(1, 0, 'h05, 'h07, rd);
        xfer(1, 1, 'h05, 'h22, rd); chk("collide_old", rd, 8'h07);
        xfer(0, 1, 'h05, 0, rd);    chk("collide_new", rd, 8'h22);
        xfer(0, 1, 'h80, 0, rd);    chk("unmapped_rd", rd, 8'h00);
        xfer(0, 1, 'hF2, 0, rd);    chk("err_after_unmapped", rd, 8'h05);

        // Reset in the middle of a write stream
        xfer(1, 0, 'hF1, 'hA5, rd);
        for (int i = 0; i < 4; i++) xfer(1, 0, i, 'h40 + i, rd);
        do_reset(1'b1, 'h04, 'h99);
        for (int i = 0; i < 5; i++) begin
            xfer(0, 1, i, 0, rd); chk("gp_after_reset", rd, 8'h00);
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int sel, a, d;
            bit w, r;
            sel = int'($urandom_range(0, 11));
            d   = int'($urandom_range(0, 255));
            if (sel <= 4)      a = int'($urandom_range(0, 15));
            else if (sel <= 7) a = int'($urandom_range('hF0, 'hF5));
            else if (sel == 8) a = int'($urandom_range(16, 'hEF));
            else if (sel == 9) a = int'($urandom_range('hF6, 'hFF));
            else begin
                a = 'hF1;
                d = ($urandom_range(0, 3) != 0) ? 'hA5 : d;
            end
            w = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 399) == 0) do_reset(w, a, d);
            else xfer(w, r, a, d, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
